// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level transforms used by the iterative encryptor.
// Block byte 0 (FIPS-197 numbering) sits in bits [127:120]; bytes are column-major.
package aes_pkg;

   typedef logic [127:0] aes_block_t;
   typedef logic [31:0]  aes_word_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;

   localparam int NUM_ROUNDS = 10;

   // Entry 0x00 is the top byte, so the table is indexed with the complement of the input.
   localparam logic [255:0][7:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[~x];
   endfunction

   function automatic aes_word_t sub_word(input aes_word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic aes_word_t mix_column(input aes_word_t w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic aes_block_t shift_rows(input aes_block_t s);
      aes_block_t o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_round_step.sv
// One combinational AES-128 round: derives the next round key on the fly and applies
// SubBytes, ShiftRows, MixColumns (bypassed on the final round) and AddRoundKey.
module aes_round_step
   import aes_pkg::*;
(
   input  aes_block_t i_state,
   input  aes_block_t i_rk,
   input  logic [7:0] i_rcon,
   input  logic       i_final,
   output aes_block_t o_state,
   output aes_block_t o_rk,
   output logic [7:0] o_rcon
);

   aes_word_t  w_temp;
   aes_block_t w_rk;
   aes_block_t w_sb;
   aes_block_t w_sr;
   aes_block_t w_mc;

   always_comb begin
      w_temp          = sub_word({i_rk[23:0], i_rk[31:24]}) ^ {i_rcon, 24'h000000};
      w_rk[127:96]    = i_rk[127:96] ^ w_temp;
      w_rk[95:64]     = i_rk[95:64]  ^ w_rk[127:96];
      w_rk[63:32]     = i_rk[63:32]  ^ w_rk[95:64];
      w_rk[31:0]      = i_rk[31:0]   ^ w_rk[63:32];
      for (int i = 0; i < 16; i++) begin
         w_sb[8*i +: 8] = sbox(i_state[8*i +: 8]);
      end
      w_sr = shift_rows(w_sb);
      w_mc = w_sr;
      if (!i_final) begin
         for (int c = 0; c < 4; c++) begin
            w_mc[32*c +: 32] = mix_column(w_sr[32*c +: 32]);
         end
      end
   end

   assign o_state = w_mc ^ w_rk;
   assign o_rk    = w_rk;
   assign o_rcon  = xtime(i_rcon);

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: UNROLL rounds per clock, valid/ready on both sides,
// opaque sideband tag returned with each ciphertext block.
module aes128_enc_iter
   import aes_pkg::*;
#(
   parameter int UNROLL = 1,
   parameter int TAG_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     plaintext,
   input  logic [127:0]     cipher_key,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     ciphertext,
   output logic [TAG_W-1:0] out_tag
);

   generate
      if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
         $error("aes128_enc_iter: UNROLL must be 1, 2, 5 or 10");
      end
   endgenerate

   localparam logic [3:0] STEP     = 4'(UNROLL);
   localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

   aes_state_e       r_state;
   aes_state_e       w_state_nxt;
   aes_block_t       r_blk;
   aes_block_t       r_rk;
   aes_block_t       r_ct;
   logic [7:0]       r_rcon;
   logic [3:0]       r_rnd;
   logic [TAG_W-1:0] r_tag;
   logic [TAG_W-1:0] r_out_tag;
   logic             w_accept;
   logic             w_last;

   aes_block_t w_st   [UNROLL+1];
   aes_block_t w_rk   [UNROLL+1];
   logic [7:0] w_rcon [UNROLL+1];

   // Reset also gates in_ready so nothing is taken while the core is held.
   assign in_ready   = ~rst & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
   assign w_accept   = in_valid & in_ready;
   assign w_last     = (r_rnd + STEP) == LAST_RND;
   assign out_valid  = (r_state == DONE);
   assign ciphertext = r_ct;
   assign out_tag    = r_out_tag;

   assign w_st[0]   = r_blk;
   assign w_rk[0]   = r_rk;
   assign w_rcon[0] = r_rcon;

   for (genvar k = 0; k < UNROLL; k++) begin : g_round
      localparam logic [3:0] RND = 4'(k + 1);
      logic w_final;
      assign w_final = (r_rnd + RND) == LAST_RND;
      aes_round_step u_step (
         .i_state (w_st[k]),
         .i_rk    (w_rk[k]),
         .i_rcon  (w_rcon[k]),
         .i_final (w_final),
         .o_state (w_st[k+1]),
         .o_rk    (w_rk[k+1]),
         .o_rcon  (w_rcon[k+1])
      );
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = w_accept ? RUN : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blk     <= '0;
         r_rk      <= '0;
         r_rcon    <= '0;
         r_rnd     <= '0;
         r_tag     <= '0;
         r_ct      <= '0;
         r_out_tag <= '0;
      end else if (w_accept) begin
         r_blk  <= plaintext ^ cipher_key;
         r_rk   <= cipher_key;
         r_rcon <= 8'h01;
         r_rnd  <= '0;
         r_tag  <= in_tag;
      end else if (r_state == RUN) begin
         r_blk  <= w_st[UNROLL];
         r_rk   <= w_rk[UNROLL];
         r_rcon <= w_rcon[UNROLL];
         r_rnd  <= r_rnd + STEP;
         if (w_last) begin
            r_ct      <= w_st[UNROLL];
            r_out_tag <= r_tag;
         end
      end
   end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Bench for aes128_enc_iter: four instances (UNROLL 1/2/5/10) against a byte-array AES model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes128_enc_iter;

   localparam int NU = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid   [NU];
   logic         in_ready   [NU];
   logic [127:0] plaintext  [NU];
   logic [127:0] cipher_key [NU];
   logic [7:0]   in_tag     [NU];
   logic         out_valid  [NU];
   logic         out_ready  [NU];
   logic [127:0] ciphertext [NU];
   logic [7:0]   out_tag    [NU];

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] sb [256];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NU; g++) begin : g_dut
      aes128_enc_iter #(
         .UNROLL ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10),
         .TAG_W  (8)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .plaintext  (plaintext[g]),
         .cipher_key (cipher_key[g]),
         .in_tag     (in_tag[g]),
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready[g]),
         .ciphertext (ciphertext[g]),
         .out_tag    (out_tag[g])
      );
   end

   function automatic int lat_of(input int u);
      return (u == 0) ? 10 : (u == 1) ? 5 : (u == 2) ? 2 : 1;
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] x);
      return {x[6:0], x[7]};
   endfunction

   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv, s, r;
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         s = inv ^ 8'h63;
         r = inv;
         for (int n = 0; n < 4; n++) begin
            r = rotl1(r);
            s = s ^ r;
         end
         sb[a] = s;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0] s [16];
      logic [7:0] k [16];
      logic [7:0] ns [16];
      logic [7:0] t [4];
      logic [7:0] rc;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) begin
         k[i] = key[127-8*i -: 8];
         s[i] = pt[127-8*i -: 8] ^ k[i];
      end
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         t[0] = sb[k[13]] ^ rc;
         t[1] = sb[k[14]];
         t[2] = sb[k[15]];
         t[3] = sb[k[12]];
         for (int i = 0; i < 16; i++) k[i] = k[i] ^ ((i < 4) ? t[i] : k[i-4]);
         rc = gmul(rc, 8'h02);
         for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) ns[w+4*c] = s[w+4*((c+w)%4)];
         for (int i = 0; i < 16; i++) s[i] = ns[i];
         if (r < 10) begin
            for (int c = 0; c < 4; c++)
               for (int i = 0; i < 4; i++)
                  ns[4*c+i] = gmul(8'h02, s[4*c+i]) ^ gmul(8'h03, s[4*c+(i+1)%4]) ^
                              s[4*c+(i+2)%4] ^ s[4*c+(i+3)%4];
            for (int i = 0; i < 16; i++) s[i] = ns[i];
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents one block (expects in_ready), then waits a bounded number of cycles for out_valid.
   task automatic run_block(input int u, input logic [127:0] pt, input logic [127:0] key,
                            input logic [7:0] tag, input bit jitter,
                            output logic [127:0] ct, output logic [7:0] otg, output int lat);
      in_valid[u]   = 1'b1;
      plaintext[u]  = pt;
      cipher_key[u] = key;
      in_tag[u]     = tag;
      @(posedge clk); #1;
      in_valid[u] = 1'b0;
      lat = 0;
      while (!out_valid[u] && lat < 40) begin
         if (jitter) begin
            plaintext[u]  = {$urandom, $urandom, $urandom, $urandom};
            cipher_key[u] = {$urandom, $urandom, $urandom, $urandom};
            in_tag[u]     = 8'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      ct  = ciphertext[u];
      otg = out_tag[u];
   endtask

   task automatic release_out(input int u);
      out_ready[u] = 1'b1;
      @(posedge clk); #1;
      out_ready[u] = 1'b0;
   endtask

   typedef struct {
      int           u;
      logic [127:0] pt;
      logic [127:0] key;
      logic [7:0]   tag;
      logic [127:0] ct;
   } vec_t;

   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   initial begin
      vec_t         tbl [6];
      logic [127:0] ct, pa, ka, pb, kb, ea, eb;
      logic [7:0]   tg, tag;
      int           lat;

      tbl[0] = '{0, C1_PT, C1_KEY, 8'ha5, C1_CT};
      tbl[1] = '{1, B_PT, B_KEY, 8'h3c, B_CT};
      tbl[2] = '{2, B_PT, B_KEY, 8'h5a, B_CT};
      tbl[3] = '{3, B_PT, B_KEY, 8'hc3, B_CT};
      tbl[4] = '{0, 128'h0, 128'h0, 8'h00, Z_CT};
      tbl[5] = '{3, 128'h0, 128'h0, 8'hff, Z_CT};

      rst = 1'b1;
      for (int u = 0; u < NU; u++) begin
         in_valid[u]   = 1'b1;
         out_ready[u]  = 1'b0;
         plaintext[u]  = 128'h0;
         cipher_key[u] = 128'h0;
         in_tag[u]     = 8'h0;
      end
      build_sbox();
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < NU; u++) begin
         chk("reset out_valid", 128'(out_valid[u]), 128'd0);
         chk("reset in_ready", 128'(in_ready[u]), 128'd0);
         chk("reset ciphertext", ciphertext[u], 128'd0);
         chk("reset out_tag", 128'(out_tag[u]), 128'd0);
         in_valid[u] = 1'b0;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int u = 0; u < NU; u++) chk("idle in_ready", 128'(in_ready[u]), 128'd1);

      for (int i = 0; i < 6; i++) begin
         run_block(tbl[i].u, tbl[i].pt, tbl[i].key, tbl[i].tag, 1'b0, ct, tg, lat);
         chk($sformatf("vec%0d ciphertext", i), ct, tbl[i].ct);
         chk($sformatf("vec%0d out_tag", i), 128'(tg), 128'(tbl[i].tag));
         chk($sformatf("vec%0d latency", i), 128'(lat), 128'(lat_of(tbl[i].u)));
         release_out(tbl[i].u);
      end

      for (int u = 0; u < NU; u++) begin
         for (int j = 0; j < 6; j++) begin
            pa  = {$urandom, $urandom, $urandom, $urandom};
            ka  = {$urandom, $urandom, $urandom, $urandom};
            tag = 8'($urandom);
            ea  = aes_ref(pa, ka);
            run_block(u, pa, ka, tag, 1'b1, ct, tg, lat);
            chk($sformatf("rand u%0d/%0d ciphertext", u, j), ct, ea);
            chk($sformatf("rand u%0d/%0d out_tag", u, j), 128'(tg), 128'(tag));
            chk($sformatf("rand u%0d/%0d latency", u, j), 128'(lat), 128'(lat_of(u)));
            release_out(u);
         end
      end

      // Backpressure in DONE, then same-edge acceptance of the held next block.
      pa = {$urandom, $urandom, $urandom, $urandom};
      ka = {$urandom, $urandom, $urandom, $urandom};
      pb = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      ea = aes_ref(pa, ka);
      eb = aes_ref(pb, kb);
      run_block(0, pa, ka, 8'h11, 1'b0, ct, tg, lat);
      chk("bp first ciphertext", ct, ea);
      in_valid[0]   = 1'b1;
      plaintext[0]  = pb;
      cipher_key[0] = kb;
      in_tag[0]     = 8'h22;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         chk("bp hold out_valid", 128'(out_valid[0]), 128'd1);
         chk("bp hold ciphertext", ciphertext[0], ea);
         chk("bp hold out_tag", 128'(out_tag[0]), 128'h11);
         chk("bp hold in_ready", 128'(in_ready[0]), 128'd0);
      end
      out_ready[0] = 1'b1;
      #1;
      chk("bp release in_ready", 128'(in_ready[0]), 128'd1);
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b0;
      chk("bp after release out_valid", 128'(out_valid[0]), 128'd0);
      chk("bp running in_ready", 128'(in_ready[0]), 128'd0);
      lat = 0;
      while (!out_valid[0] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp second latency", 128'(lat), 128'd10);
      chk("bp second ciphertext", ciphertext[0], eb);
      chk("bp second out_tag", 128'(out_tag[0]), 128'h22);
      release_out(0);

      // Asynchronous reset four cycles into RUN; the previous result is still registered.
      in_valid[0]   = 1'b1;
      plaintext[0]  = C1_PT;
      cipher_key[0] = C1_KEY;
      in_tag[0]     = 8'h77;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst async out_valid", 128'(out_valid[0]), 128'd0);
      chk("rst async ciphertext", ciphertext[0], 128'd0);
      chk("rst async out_tag", 128'(out_tag[0]), 128'd0);
      chk("rst async in_ready", 128'(in_ready[0]), 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post-rst stale out_valid", 128'(out_valid[0]), 128'd0);
      run_block(0, C1_PT, C1_KEY, 8'h78, 1'b0, ct, tg, lat);
      chk("post-rst ciphertext", ct, C1_CT);
      chk("post-rst out_tag", 128'(tg), 128'h78);
      chk("post-rst latency", 128'(lat), 128'd10);
      release_out(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aes128_enc_iter.md
Name: aes128_enc_iter

Overview:
- Parametrised successor to the team's fixed 11-stage pipelined AES-128 encryptor.
- Iterative AES-128 encrypt core. UNROLL rounds are computed per clock, trading area against latency.
- Adds valid/ready handshakes on input and output, a sideband tag, and on-the-fly key expansion.
- Sits between the block-cipher mode logic and the data path, and replaces the free-running pipeline where area matters.

Parameters:
- UNROLL, 1, AES rounds evaluated per clock. Legal values: 1, 2, 5, 10. Any other value is an elaboration error.
- TAG_W, 8, width of the opaque sideband tag carried with each block.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  plaintext/key/tag presented.
- in_ready  out  1  core can accept a block this cycle.
- plaintext  in  128  input block; bits [127:120] are FIPS-197 byte 0.
- cipher_key  in  128  AES-128 key; same byte order as plaintext.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts the result.
- ciphertext  out  128  result block.
- out_tag  out  TAG_W  tag of the block in ciphertext.

Behaviour:
- Clock: one clock, clk.
- Reset: rst is asynchronous and active-high.
  - While rst is high: state=IDLE, out_valid=0, ciphertext=0, out_tag=0, round counter=0, round-key and rcon registers=0.
  - in_ready=0 while rst is asserted.
- FSM: three states, IDLE, RUN and DONE.
- in_ready (combinational) = (state==IDLE) | (state==DONE & out_ready).
- Accept: at the edge where in_valid & in_ready are both high:
  - state <= plaintext ^ cipher_key;
  - rk <= cipher_key; rcon <= 8'h01; rnd <= 0; tag captured; FSM -> RUN.
- RUN: each cycle applies UNROLL consecutive rounds to the state. For each round r (1..10):
  - derive rk_r from rk_{r-1}: RotWord, SubWord, xor rcon, word-chain xor;
  - apply SubBytes, ShiftRows, MixColumns (skipped when r==10), then AddRoundKey rk_r;
  - update rcon via xtime.
- Round counter: rnd advances by UNROLL per cycle. When rnd reaches 10, the FSM goes to DONE and the result is registered into ciphertext/out_tag.
- Latency: with acceptance at edge E0, out_valid rises after edge E0 + 10/UNROLL (10, 5, 2 or 1 cycles).
- DONE:
  - out_valid=1; ciphertext and out_tag are held stable until out_ready=1.
  - At the edge with out_ready=1: if in_valid=1, the next block is accepted on that same edge (FSM -> RUN); otherwise FSM -> IDLE and out_valid=0.
- Throughput: one block per 10/UNROLL + 1 cycles under continuous valid/ready.
- Input changes: plaintext, cipher_key and in_tag are sampled only at acceptance. Later changes are ignored.
- in_valid held while not ready: no effect. The input is not lost; the producer holds it.
- Reset mid-RUN or mid-DONE: the in-flight block is discarded, all outputs return to their reset values, and no partial ciphertext is ever presented.
- in_ready depends combinationally on out_ready. No combinational path exists from in_valid to any output.

Decomposition:
- Package aes_pkg:
  - sbox function (256-entry);
  - xtime and mix_column functions;
  - the shift_rows byte permutation;
  - typedefs: aes_block_t (128-bit), aes_word_t (32-bit);
  - constant NUM_ROUNDS=10.
- Sub-module aes_round_step, purely combinational, instantiated UNROLL times in a generate chain:
  - inputs: state, rk, rcon, final_round flag;
  - outputs: next state, next rk, next rcon.

Test Plan:
- UNROLL=1, FIPS-197 C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after acceptance, out_tag equals in_tag.
- UNROLL=2, 5 and 10, FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32 at latencies 5, 2 and 1 respectively.
- All-zero plaintext and key -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Backpressure: hold out_ready=0 for 7 cycles in DONE -> out_valid, ciphertext and out_tag stay constant and in_ready=0; release with in_valid=1 -> next block accepted on the same edge, and both results are correct in order with their tags.
- Input perturbation: change plaintext and key every cycle during RUN -> result equals encryption of the values captured at acceptance.
- Reset mid-operation: assert rst 4 cycles into RUN -> out_valid, ciphertext and out_tag drop to 0 immediately and asynchronously. After release, a fresh C.1 vector completes correctly with no stale output.
